// File: rtl/booth2_operand_prep.sv
// Operand prep for the 16x16 Booth-2 multiplier: registers A, -A and the eight radix-4 codes of B behind a 2-entry skid buffer.
// Optional `define BOOTH2_PREP_ZERO_DETECT_EN adds out_zero, flagged when either operand is zero.
module booth2_operand_prep #(
  parameter int WIDTH  = 16,
  parameter int NUM_PP = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_A,
  input  logic [WIDTH-1:0]          in_B,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          A,
  output logic [WIDTH-1:0]          inversed_A,
  output logic [1:0]                code_pp1,
  output logic [3*(NUM_PP-1)-1:0]   code_pp
`ifdef BOOTH2_PREP_ZERO_DETECT_EN
  ,
  output logic                      out_zero
`endif
);

  localparam int CW     = 3 * (NUM_PP - 1);
  localparam int BASE_W = 2 * WIDTH + 2 + CW;
`ifdef BOOTH2_PREP_ZERO_DETECT_EN
  localparam int BW     = BASE_W + 1;
`else
  localparam int BW     = BASE_W;
`endif

  // Bundle layout, LSB first: codes, code_pp1, A, -A, [zero flag]
  localparam int C1_LO  = CW;
  localparam int A_LO   = CW + 2;
  localparam int NEG_LO = CW + 2 + WIDTH;

  logic [WIDTH-1:0] neg_a;
  logic [CW-1:0]    codes_new;
  logic [BW-1:0]    bundle_new;

  logic [BW-1:0]    main_q, main_d;
  logic [BW-1:0]    skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;

  logic             in_xfer;
  logic             out_xfer;

  assign neg_a = (~in_A) + WIDTH'(1);

  // Group gi overlaps the previous group by one bit: {B[2gi+1], B[2gi], B[2gi-1]}
  genvar gi;
  generate
    for (gi = 1; gi < NUM_PP; gi++) begin : g_code
      assign codes_new[3*gi-1 -: 3] = in_B[2*gi+1 -: 3];
    end
  endgenerate

  assign bundle_new[CW-1:0]                = codes_new;
  assign bundle_new[C1_LO+1:C1_LO]         = in_B[1:0];
  assign bundle_new[A_LO+WIDTH-1:A_LO]     = in_A;
  assign bundle_new[NEG_LO+WIDTH-1:NEG_LO] = neg_a;
`ifdef BOOTH2_PREP_ZERO_DETECT_EN
  assign bundle_new[BW-1] = (in_A == '0) || (in_B == '0);
`endif

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (out_xfer) begin
      if (skid_valid_q) begin
        main_d = skid_q;
        if (in_xfer) begin
          skid_d = bundle_new;
        end else begin
          skid_valid_d = 1'b0;
        end
      end else if (in_xfer) begin
        main_d = bundle_new;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      if (!main_valid_q) begin
        main_d       = bundle_new;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = bundle_new;
        skid_valid_d = 1'b1;
      end
    end
    // Registered ready: only the skid occupancy decides, never out_ready directly
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_valid_q;
  assign code_pp    = main_q[CW-1:0];
  assign code_pp1   = main_q[C1_LO+1:C1_LO];
  assign A          = main_q[A_LO+WIDTH-1:A_LO];
  assign inversed_A = main_q[NEG_LO+WIDTH-1:NEG_LO];
`ifdef BOOTH2_PREP_ZERO_DETECT_EN
  assign out_zero   = main_q[BW-1];
`endif

endmodule

// File: tb/tb_booth2_operand_prep.sv
// Bench for booth2_operand_prep: queue-based model of the accepted bundles plus directed literal checks.
module tb_booth2_operand_prep;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_A = '0;
  logic [15:0] in_B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] A;
  logic [15:0] inversed_A;
  logic [1:0]  code_pp1;
  logic [20:0] code_pp;
`ifdef BOOTH2_PREP_ZERO_DETECT_EN
  logic        out_zero;
`endif

  booth2_operand_prep #(.WIDTH(16), .NUM_PP(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_A       (in_A),
    .in_B       (in_B),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .A          (A),
    .inversed_A (inversed_A),
    .code_pp1   (code_pp1),
    .code_pp    (code_pp)
`ifdef BOOTH2_PREP_ZERO_DETECT_EN
    ,
    .out_zero   (out_zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] inv;
    logic [1:0]  c1;
    logic [20:0] cpp;
    logic        z;
  } bundle_t;

  int          total = 0;
  int          bad = 0;
  int          edges = 0;
  int          cyc = 0;
  bundle_t     q[$];
  logic [15:0] out_log[$];
  int          out_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Negation by modular arithmetic, codes as successive 3-bit windows of {B,0}
  function automatic bundle_t model(input logic [15:0] a, input logic [15:0] b);
    bundle_t     r;
    logic [16:0] bx;
    r.a   = a;
    r.inv = 16'(32'h10000 - 32'(a));
    bx    = {b, 1'b0};
    r.c1  = 2'(bx >> 1);
    r.cpp = '0;
    for (int i = 1; i < 8; i++) r.cpp[3*i-3 +: 3] = 3'(bx >> (2*i));
    r.z   = (a == 16'd0) || (b == 16'd0);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else if (edges < 2) edges <= edges + 1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bundle_t e;
    logic    mr;
    if (!rst_n) begin
      q.delete();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_A", 32'(A), 32'd0);
      chk("rst_inv", 32'(inversed_A), 32'd0);
      chk("rst_codes", 32'({code_pp1, code_pp}), 32'd0);
    end else begin
      mr = (edges >= 1) && (q.size() < 2);
      if (edges >= 1) chk("in_ready", 32'(in_ready), 32'(mr));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (out_valid && q.size() > 0) begin
        e = q[0];
        chk("A", 32'(A), 32'(e.a));
        chk("inversed_A", 32'(inversed_A), 32'(e.inv));
        chk("code_pp1", 32'(code_pp1), 32'(e.c1));
        chk("code_pp", 32'(code_pp), 32'(e.cpp));
`ifdef BOOTH2_PREP_ZERO_DETECT_EN
        chk("out_zero", 32'(out_zero), 32'(e.z));
`endif
      end
      if (q.size() > 0 && out_ready) begin
        out_log.push_back(A);
        out_cyc.push_back(cyc);
        void'(q.pop_front());
      end
      if (in_valid && mr) q.push_back(model(in_A, in_B));
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int   n;
    logic acc;
    in_valid = 1'b1;
    in_A = a;
    in_B = b;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    step(1);
    chk("ready_after_rst", 32'(in_ready), 32'd1);
    chk("valid_after_rst", 32'(out_valid), 32'd0);

    // Single op, B=6
    out_ready = 1'b1;
    send(16'h0003, 16'h0006);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_A", 32'(A), 32'h0003);
    chk("t1_inv", 32'(inversed_A), 32'hFFFD);
    chk("t1_c1", 32'(code_pp1), 32'h2);
    chk("t1_cpp", 32'(code_pp), 32'h000003);

    // Negative multiplier
    send(16'h1234, 16'hFFFF);
    chk("t2_inv", 32'(inversed_A), 32'hEDCC);
    chk("t2_c1", 32'(code_pp1), 32'h3);
    chk("t2_cpp", 32'(code_pp), 32'h1FFFFF);

    // Most-negative multiplicand wraps
    send(16'h8000, 16'h0001);
    chk("wrap_inv", 32'(inversed_A), 32'h8000);
    chk("wrap_c1", 32'(code_pp1), 32'h1);
    chk("wrap_cpp", 32'(code_pp), 32'h0);
    step(2);

    // Back-pressure: two fit, third is refused while outputs hold the first
    out_ready = 1'b0;
    out_log.delete();
    out_cyc.delete();
    send(16'h0011, 16'd1);
    send(16'h0012, 16'd2);
    in_valid = 1'b1;
    in_A = 16'h0013;
    in_B = 16'd3;
    @(negedge clk);
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    chk("bp_hold_A", 32'(A), 32'h0011);
    chk("bp_hold_c1", 32'(code_pp1), 32'h1);
    step(1);
    @(negedge clk);
    chk("bp_ready_low2", 32'(in_ready), 32'd0);
    chk("bp_hold_A2", 32'(A), 32'h0011);
    step(1);
    out_ready = 1'b1;
    send(16'h0013, 16'd3);
    send(16'h0014, 16'd4);
    step(3);
    chk("bp_count", 32'(out_log.size()), 32'd4);
    if (out_log.size() == 4) begin
      chk("bp_order0", 32'(out_log[0]), 32'h0011);
      chk("bp_order1", 32'(out_log[1]), 32'h0012);
      chk("bp_order2", 32'(out_log[2]), 32'h0013);
      chk("bp_order3", 32'(out_log[3]), 32'h0014);
      chk("bp_no_gap", 32'(out_cyc[3] - out_cyc[0]), 32'd3);
    end

    // Reset with both entries occupied
    out_ready = 1'b0;
    send(16'h0021, 16'd5);
    send(16'h0022, 16'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_A", 32'(A), 32'd0);
    chk("mid_rst_inv", 32'(inversed_A), 32'd0);
    chk("mid_rst_codes", 32'({code_pp1, code_pp}), 32'd0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step(1);
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    step(3);
    send(16'h0031, 16'd7);
    chk("post_rst_A", 32'(A), 32'h0031);
    chk("post_rst_c1", 32'(code_pp1), 32'h3);
    chk("post_rst_cpp", 32'(code_pp), 32'h000003);

`ifdef BOOTH2_PREP_ZERO_DETECT_EN
    send(16'h0000, 16'h7FFF);
    chk("zero_set", 32'(out_zero), 32'd1);
    send(16'h0001, 16'h0001);
    chk("zero_clr", 32'(out_zero), 32'd0);
`endif

    step(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth2_operand_prep.md
Name: booth2_operand_prep

Overview:
- Registered operand-preparation stage directly upstream of the Booth-2 partial-product decoders of the 16x16 signed multiplier.
- Accepts multiplicand A and multiplier B over a valid/ready handshake.
- Computes -A and the eight radix-4 Booth codes of B.
- Presents them, registered, to the decoder array (pp1 decoder plus seven general decoders) through a 2-entry skid buffer, so full throughput is kept under back-pressure.

Parameters:
- WIDTH, 16, operand width; only 16 is supported (decoders are fixed at 16 bits).
- NUM_PP, 8, number of partial products = WIDTH/2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A/B operand pair valid.
- in_ready  output  1  stage can accept a pair this cycle.
- in_A  input  16  multiplicand, two's complement.
- in_B  input  16  multiplier, two's complement.
- out_valid  output  1  output bundle valid.
- out_ready  input  1  decoder/compressor pipeline accepts the bundle.
- A  output  16  registered multiplicand.
- inversed_A  output  16  registered -A, 16-bit two's complement.
- code_pp1  output  2  {B[1],B[0]} for pp1; implied B[-1]=0.
- code_pp  output  21  groups 1..7, 3 bits each; group i = code_pp[3i-1:3i-3] = {B[2i+1],B[2i],B[2i-1]}.

Behaviour:
- Reset (async assert, sync release): out_valid=0, main and skid entries invalid, all data outputs 0, in_ready=1 from the first edge after release.
- Input transfer occurs when in_valid&in_ready. Output transfer occurs when out_valid&out_ready.
- Computation is performed on the input side, before registering:
  - neg = (~in_A)+1, truncated to 16 bits.
  - Codes are sliced from in_B.
  - A/inversed_A/codes are captured as one bundle.
- Storage: main register (drives outputs) plus one skid register.
  - in_ready = ~skid_valid, driven from a flop with no combinational path from out_ready.
  - out_valid = main_valid.
- Per-cycle update:
  - Output transfer with skid valid: skid moves into main. If an input transfer also occurs, the new bundle enters skid; otherwise skid empties.
  - Output transfer with skid empty: an input transfer loads main; otherwise main_valid=0.
  - No output transfer, main empty: an input transfer loads main.
  - No output transfer, main full: an input transfer loads skid, and in_ready drops the next cycle.
- Latency: 1 cycle from input transfer to out_valid. Throughput is 1 bundle/cycle while out_ready=1.
- Bundles leave in acceptance order; none is dropped or duplicated.
- Output data is held stable while out_valid=1 and out_ready=0.
- Boundary: in_A=0x8000 gives inversed_A=0x8000 (wrap). Downstream correction for this case is outside this block.
- Reset asserted mid-operation discards both entries immediately. out_valid falls asynchronously.

Optional Feature:
- Macro BOOTH2_PREP_ZERO_DETECT_EN.
- Defined:
  - Extra output port out_zero (1 bit) is registered with the bundle and travels through the skid path.
  - out_zero=1 iff in_A==0 or in_B==0. Downstream uses it to gate the tree and force the product to 0.
  - out_zero resets to 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Single op, out_ready=1: in_A=0x0003, in_B=0x0006 for one cycle -> next cycle out_valid=1, A=0x0003, inversed_A=0xFFFD, code_pp1=2'b10, code_pp group1=3'b011, groups 2..7=3'b000.
- Negative multiplier: in_A=0x1234, in_B=0xFFFF -> inversed_A=0xEDCC, code_pp1=2'b11, all groups 1..7=3'b111.
- Back-pressure:
  - Drive 4 back-to-back pairs (B=1,2,3,4) with out_ready=0 -> accepts 2, in_ready=0 on the 3rd cycle, outputs hold B=1.
  - Then raise out_ready -> bundles emerge in order 1,2,3,4 with no gaps once streaming.
- Wrap: in_A=0x8000, in_B=0x0001 -> inversed_A=0x8000, code_pp1=2'b01.
- Reset mid-operation: with 2 bundles buffered, pulse rst_n low -> out_valid=0 immediately, outputs 0, in_ready=1 after release, no stale bundle ever appears.
- With BOOTH2_PREP_ZERO_DETECT_EN defined: in_A=0x0000, in_B=0x7FFF -> out_zero=1. Then in_A=0x0001, in_B=0x0001 -> out_zero=0.
